ntt_stage_controller: RTL and testbench
=======================================

Name: ntt_stage_controller

Overview:
- Sequences one ntt_core through all butterfly stages of a forward NTT: generates log_m, i, mode, read address, ping-pong bank selects and delayed write-back enables/addresses.
- Sits between the top-level host/load logic and the ntt_core array. All cores share one controller; the inter-core data routing on write-back is external.
- Start/busy/done handshake to the host.

Parameters:
- LOG_N, 12, log2 of the polynomial length; number of stages = LOG_N.
- LOG_CORE_COUNT, 5, log2 of the number of cores; must match the cores.
- PIPE_LATENCY, 4, cycles from a read address being issued to its butterfly results being ready for write-back (RAM + twiddle register + butterfly). Must be ≥ 1.
- WORDS, 2**(LOG_N-LOG_CORE_COUNT-2), read words per RAM per stage (32 at defaults).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin transform; sampled in IDLE only
- abort  in  1  synchronous abort to IDLE; has priority over all other inputs
- busy  out  1  high from the cycle after start is accepted until DONE is left
- done  out  1  one-cycle pulse in DONE
- stage_done  out  1  one-cycle pulse in each NEXT state and in DONE
- log_m  out  4  current stage index, 0..LOG_N-1
- mode  out  2  0 if log_m<LOG_CORE_COUNT, 1 if log_m==LOG_CORE_COUNT, 2 otherwise
- i  out  10  zero-extended read index (valid in all modes; consumed by cores in mode 1)
- read_address  out  9  RAM read word address
- read_select  out  1  bank being read
- write_select  out  1  bank being written; always ~read_select
- upper_write_enable  out  1  upper RAM write strobe
- lower_write_enable  out  1  lower RAM write strobe; identical timing to upper
- upper_write_address  out  9  write address for the upper RAM
- lower_write_address  out  9  write address for the lower RAM; same value as upper
- result_bank  out  1  bank holding the final result; valid when done=1

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0, except write_select=1.
  - Delay-line valid bits cleared.
- All outputs are registered.
- FSM states: IDLE, READ, DRAIN, NEXT, DONE.
- IDLE:
  - start=1 → READ.
  - In the same edge, load log_m=0, read_address=0, read_select=0, write_select=1.
- READ:
  - One read per cycle. read_address and i step 0..WORDS-1.
  - The address is registered and presented in the cycle it is valid.
  - After the cycle with read_address=WORDS-1 → DRAIN.
- DRAIN: lasts exactly PIPE_LATENCY cycles; no reads issued; read_address holds WORDS-1.
- Write-back:
  - The read issued in cycle c produces write enables =1 in cycle c+PIPE_LATENCY, with write addresses equal to its read address.
  - Implemented as a PIPE_LATENCY-deep address/valid shift register.
  - The last write of a stage coincides with the last DRAIN cycle.
- NEXT (1 cycle):
  - Toggle read_select and write_select.
  - log_m+1; read_address=0, i=0.
  - Pulse stage_done → READ.
  - NEXT is entered after DRAIN only when log_m<LOG_N-1. Otherwise DRAIN → DONE.
- DONE (1 cycle):
  - done=1, stage_done=1.
  - result_bank=write_select of the final stage → IDLE.
  - busy falls on the following cycle.
- start while not IDLE is ignored.
- start and abort in the same cycle: abort wins; stay/return IDLE.
- abort in any state:
  - Next cycle state=IDLE.
  - Write enables forced 0 and delay-line valid bits cleared, so in-flight writes are discarded.
  - busy=0, selects reset to read_select=0 / write_select=1, done not pulsed.
- Cycles per stage = WORDS+PIPE_LATENCY+1 (37 at defaults); the last stage replaces NEXT with DONE.
- No bank is read and written in the same stage: read_select≠write_select at all times.

Test Plan:
- Reset mid-READ (rst_n low at stage 3, read_address=10) → all outputs immediately 0, write_select=1. After release, state is IDLE and busy=0.
- Defaults, start pulse at cycle 0 → busy=1 from cycle 1; READ cycles 1..32 with read_address 0..31; write enables at cycles 5..36 with addresses 0..31; stage_done at 37; log_m=1 at 38; done at cycle 444; busy=0 at 445; result_bank=0.
- Mode sweep over the full run → mode=0 for log_m 0..4, mode=1 for log_m 5, mode=2 for log_m 6..11. read_select and write_select toggle exactly 11 times and are never equal.
- abort asserted at stage 2 DRAIN cycle 2 → next cycle IDLE; no write enable after abort; done never pulses. A fresh start then runs a full 444-cycle transform from log_m=0.
- start re-pulsed at cycles 10 and 200 during a run, and start+abort together in IDLE → no effect on the sequence/timing; remains IDLE.
- PIPE_LATENCY=1, LOG_N=8, LOG_CORE_COUNT=3 (WORDS=8) → stage length 10 cycles; each write enable exactly one cycle after its read; done at cycle 8*10+... = 80 after start.

Source files
------------

// File: rtl/ntt_stage_controller.sv
// Stage sequencer for one forward NTT: walks every butterfly stage, issues reads,
// and replays each read address as a write-back strobe PIPE_LATENCY cycles later.
module ntt_stage_controller #(
    parameter int LOG_N          = 12,
    parameter int LOG_CORE_COUNT = 5,
    parameter int PIPE_LATENCY   = 4,
    parameter int WORDS          = 2 ** (LOG_N - LOG_CORE_COUNT - 2)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       stage_done,
    output logic [3:0] log_m,
    output logic [1:0] mode,
    output logic [9:0] i,
    output logic [8:0] read_address,
    output logic       read_select,
    output logic       write_select,
    output logic       upper_write_enable,
    output logic       lower_write_enable,
    output logic [8:0] upper_write_address,
    output logic [8:0] lower_write_address,
    output logic       result_bank
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int DCW = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(PIPE_LATENCY - 1);
    localparam logic [8:0]     LAST_ADDR  = 9'(WORDS - 1);
    localparam logic [3:0]     LAST_STAGE = 4'(LOG_N - 1);
    localparam logic [3:0]     CORE_STAGE = 4'(LOG_CORE_COUNT);

    state_t           state_r;
    state_t           state_s;
    logic [DCW-1:0]   drain_cnt_r;
    logic [DCW-1:0]   drain_cnt_s;
    logic [8:0]       addr_r;
    logic [8:0]       addr_s;
    logic [3:0]       log_m_r;
    logic [3:0]       log_m_s;
    logic             read_select_r;
    logic             read_select_s;
    logic             write_select_r;
    logic             write_select_s;
    logic             result_bank_r;
    logic             result_bank_s;
    logic             busy_r;
    logic             done_r;
    logic             stage_done_r;
    logic [1:0]       mode_r;
    logic [1:0]       mode_s;

    // Write-back delay line: slot k holds a read issued k+1 cycles ago.
    logic [PIPE_LATENCY-1:0]       dl_valid_r;
    logic [PIPE_LATENCY-1:0][8:0]  dl_addr_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and next-value decode for every sequencing register.
    always_comb begin
        state_s        = state_r;
        drain_cnt_s    = drain_cnt_r;
        addr_s         = addr_r;
        log_m_s        = log_m_r;
        read_select_s  = read_select_r;
        write_select_s = write_select_r;
        result_bank_s  = result_bank_r;
        if (abort) begin
            state_s        = ST_IDLE;
            drain_cnt_s    = '0;
            addr_s         = 9'd0;
            log_m_s        = 4'd0;
            read_select_s  = 1'b0;
            write_select_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_s        = ST_READ;
                        addr_s         = 9'd0;
                        log_m_s        = 4'd0;
                        read_select_s  = 1'b0;
                        write_select_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (addr_r == LAST_ADDR) begin
                        state_s     = ST_DRAIN;
                        drain_cnt_s = '0;
                    end else begin
                        addr_s = addr_r + 9'd1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_r == DRAIN_LAST) begin
                        if (log_m_r == LAST_STAGE) begin
                            state_s       = ST_DONE;
                            result_bank_s = write_select_r;
                        end else begin
                            state_s = ST_NEXT;
                        end
                    end else begin
                        drain_cnt_s = drain_cnt_r + DCW'(1);
                    end
                end
                ST_NEXT: begin
                    state_s        = ST_READ;
                    addr_s         = 9'd0;
                    log_m_s        = log_m_r + 4'd1;
                    read_select_s  = ~read_select_r;
                    write_select_s = ~write_select_r;
                end
                ST_DONE: begin
                    state_s        = ST_IDLE;
                    addr_s         = 9'd0;
                    log_m_s        = 4'd0;
                    read_select_s  = 1'b0;
                    write_select_s = 1'b1;
                end
                default: begin
                    state_s        = ST_IDLE;
                    drain_cnt_s    = '0;
                    addr_s         = 9'd0;
                    log_m_s        = 4'd0;
                    read_select_s  = 1'b0;
                    write_select_s = 1'b1;
                end
            endcase
        end

        if (log_m_s < CORE_STAGE) begin
            mode_s = 2'd0;
        end else if (log_m_s == CORE_STAGE) begin
            mode_s = 2'd1;
        end else begin
            mode_s = 2'd2;
        end
    end

    // Registered sequencing outputs, all derived from the decoded next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt_r    <= '0;
            addr_r         <= 9'd0;
            log_m_r        <= 4'd0;
            read_select_r  <= 1'b0;
            write_select_r <= 1'b1;
            result_bank_r  <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            stage_done_r   <= 1'b0;
            mode_r         <= 2'd0;
        end else begin
            drain_cnt_r    <= drain_cnt_s;
            addr_r         <= addr_s;
            log_m_r        <= log_m_s;
            read_select_r  <= read_select_s;
            write_select_r <= write_select_s;
            result_bank_r  <= result_bank_s;
            busy_r         <= (state_s != ST_IDLE);
            done_r         <= (state_s == ST_DONE);
            stage_done_r   <= (state_s == ST_NEXT) || (state_s == ST_DONE);
            mode_r         <= mode_s;
        end
    end

    // Delay line; abort empties it so in-flight butterflies are never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_valid_r <= '0;
            dl_addr_r  <= '0;
        end else if (abort) begin
            dl_valid_r <= '0;
            dl_addr_r  <= '0;
        end else begin
            dl_valid_r[0] <= (state_r == ST_READ);
            dl_addr_r[0]  <= addr_r;
            for (int k = 1; k < PIPE_LATENCY; k++) begin
                dl_valid_r[k] <= dl_valid_r[k-1];
                dl_addr_r[k]  <= dl_addr_r[k-1];
            end
        end
    end

    assign busy                = busy_r;
    assign done                = done_r;
    assign stage_done          = stage_done_r;
    assign log_m               = log_m_r;
    assign mode                = mode_r;
    assign i                   = {1'b0, addr_r};
    assign read_address        = addr_r;
    assign read_select         = read_select_r;
    assign write_select        = write_select_r;
    assign upper_write_enable  = dl_valid_r[PIPE_LATENCY-1];
    assign lower_write_enable  = dl_valid_r[PIPE_LATENCY-1];
    assign upper_write_address = dl_addr_r[PIPE_LATENCY-1];
    assign lower_write_address = dl_addr_r[PIPE_LATENCY-1];
    assign result_bank         = result_bank_r;

endmodule

// File: tb/tb_ntt_stage_controller.sv
// Scoreboard bench: two controller configurations share one stimulus stream; a
// timeline model predicts every output cycle and per-instance monitors compare.
module tb_ntt_stage_controller;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       stage_done;
        logic [3:0] log_m;
        logic [1:0] mode;
        logic [9:0] i;
        logic [8:0] raddr;
        logic       rsel;
        logic       wsel;
        logic       uwe;
        logic       lwe;
        logic [8:0] uwa;
        logic [8:0] lwa;
        logic       rb;
    } out_t;

    logic clk;
    logic rst_n;
    logic start;
    logic abort;

    logic       a_busy, a_done, a_sd, a_rsel, a_wsel, a_uwe, a_lwe, a_rb;
    logic [3:0] a_log_m;
    logic [1:0] a_mode;
    logic [9:0] a_i;
    logic [8:0] a_raddr, a_uwa, a_lwa;
    logic       b_busy, b_done, b_sd, b_rsel, b_wsel, b_uwe, b_lwe, b_rb;
    logic [3:0] b_log_m;
    logic [1:0] b_mode;
    logic [9:0] b_i;
    logic [8:0] b_raddr, b_uwa, b_lwa;

    ntt_stage_controller dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(a_busy), .done(a_done), .stage_done(a_sd), .log_m(a_log_m),
        .mode(a_mode), .i(a_i), .read_address(a_raddr), .read_select(a_rsel),
        .write_select(a_wsel), .upper_write_enable(a_uwe), .lower_write_enable(a_lwe),
        .upper_write_address(a_uwa), .lower_write_address(a_lwa), .result_bank(a_rb)
    );

    ntt_stage_controller #(.LOG_N(8), .LOG_CORE_COUNT(3), .PIPE_LATENCY(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(b_busy), .done(b_done), .stage_done(b_sd), .log_m(b_log_m),
        .mode(b_mode), .i(b_i), .read_address(b_raddr), .read_select(b_rsel),
        .write_select(b_wsel), .upper_write_enable(b_uwe), .lower_write_enable(b_lwe),
        .upper_write_address(b_uwa), .lower_write_address(b_lwa), .result_bank(b_rb)
    );

    out_t act_a, act_b;
    assign act_a = {a_busy, a_done, a_sd, a_log_m, a_mode, a_i, a_raddr, a_rsel, a_wsel,
                    a_uwe, a_lwe, (a_uwe ? a_uwa : 9'd0), (a_lwe ? a_lwa : 9'd0), a_rb};
    assign act_b = {b_busy, b_done, b_sd, b_log_m, b_mode, b_i, b_raddr, b_rsel, b_wsel,
                    b_uwe, b_lwe, (b_uwe ? b_uwa : 9'd0), (b_lwe ? b_lwa : 9'd0), b_rb};

    // Per-instance configuration: LOG_N, LOG_CORE_COUNT, PIPE_LATENCY, WORDS.
    int cfg_logn [2] = '{12, 8};
    int cfg_lcc  [2] = '{5, 3};
    int cfg_p    [2] = '{4, 1};
    int cfg_w    [2] = '{32, 8};

    bit run [2];
    int t   [2];
    bit rb  [2];

    out_t q_a [$];
    out_t q_b [$];

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs expected at offset t (1 = first cycle after start accepted) of a run.
    function automatic out_t model_out(input int j, input bit running, input int tt, input bit rbank);
        out_t o;
        int L, k, q, w, p;
        o = '0;
        o.wsel = 1'b1;
        o.rb = rbank;
        w = cfg_w[j];
        p = cfg_p[j];
        L = w + p + 1;
        if (running) begin
            k = (tt - 1) / L;
            q = (tt - 1) % L;
            o.busy = 1'b1;
            o.log_m = 4'(k);
            o.mode = (k < cfg_lcc[j]) ? 2'd0 : ((k == cfg_lcc[j]) ? 2'd1 : 2'd2);
            o.rsel = (k % 2) == 1;
            o.wsel = !o.rsel;
            o.raddr = (q < w) ? 9'(q) : 9'(w - 1);
            o.i = {1'b0, o.raddr};
            o.stage_done = (q == L - 1);
            o.done = o.stage_done && (k == cfg_logn[j] - 1);
            if (q >= p && q < w + p) begin
                o.uwe = 1'b1;
                o.lwe = 1'b1;
                o.uwa = 9'(q - p);
                o.lwa = 9'(q - p);
            end
        end
        return o;
    endfunction

    task automatic model_step(input int j, input bit st, input bit ab);
        int total;
        total = cfg_logn[j] * (cfg_w[j] + cfg_p[j] + 1);
        if (!rst_n) begin
            run[j] = 1'b0;
            t[j] = 0;
            rb[j] = 1'b0;
        end else if (ab) begin
            run[j] = 1'b0;
        end else if (run[j]) begin
            if (t[j] == total) begin
                run[j] = 1'b0;
            end else begin
                t[j] = t[j] + 1;
                if (t[j] == total) rb[j] = ((cfg_logn[j] - 1) % 2) == 0;
            end
        end else if (st) begin
            run[j] = 1'b1;
            t[j] = 1;
        end
        if (j == 0) q_a.push_back(model_out(j, run[j], t[j], rb[j]));
        else        q_b.push_back(model_out(j, run[j], t[j], rb[j]));
    endtask

    task automatic check(input string nm, input out_t e, input out_t a);
        n_cmp++;
        if (e !== a) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%h required=%h", nm, $time, a, e);
        end
    endtask

    // Monitors: one pop-and-compare per cycle per instance, away from the clock edge.
    always @(negedge clk) begin
        if (q_a.size() > 0) check("cfg_default", q_a.pop_front(), act_a);
    end

    always @(negedge clk) begin
        if (q_b.size() > 0) check("cfg_small", q_b.pop_front(), act_b);
    end

    task automatic step(input bit st, input bit ab);
        start = st;
        abort = ab;
        @(posedge clk);
        model_step(0, st, ab);
        model_step(1, st, ab);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Full run with ignored start re-pulses at cycles 10 and 200.
        step(1'b1, 1'b0);
        for (int c = 1; c <= 450; c++) step((c == 10) || (c == 200), 1'b0);

        // start together with abort in IDLE stays in IDLE.
        step(1'b1, 1'b1);
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0);

        // Abort in the second DRAIN cycle of stage 2 (offset 2*37+32+2).
        step(1'b1, 1'b0);
        for (int c = 1; c <= 107; c++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        for (int c = 0; c < 5; c++) step(1'b0, 1'b0);

        // Fresh full transform after the abort.
        step(1'b1, 1'b0);
        for (int c = 1; c <= 450; c++) step(1'b0, 1'b0);

        // Asynchronous reset at stage 3, read_address 10 (offset 3*37+11).
        step(1'b1, 1'b0);
        for (int c = 1; c <= 121; c++) step(1'b0, 1'b0);
        #6;
        rst_n = 1'b0;
        run[0] = 1'b0; rb[0] = 1'b0;
        run[1] = 1'b0; rb[1] = 1'b0;
        #1;
        check("async_reset_default", model_out(0, 1'b0, 0, 1'b0), act_a);
        check("async_reset_small", model_out(1, 1'b0, 0, 1'b0), act_b);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0);

        // Randomized start/abort traffic.
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 599) == 0);
        end
        for (int c = 0; c < 450; c++) step(1'b0, 1'b0);

        #6;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
